mdu_iter: RTL and testbench

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_iter.sv | 231 +++++++++++++++++++++++
 tb/tb_mdu_iter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RISC-V M-extension multiply/divide unit.
//
// One operation at a time. Multiply is a radix-2 shift-add on operand
// magnitudes into a 2*XLEN product register. Divide is a restoring
// shift-subtract that produces one quotient bit per cycle. Every normal
// operation spends exactly XLEN cycles in CALC, including the W variants.
// Divide by zero and signed overflow skip CALC and go straight to DONE.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   op/word/opnum1/opnum2 valid this cycle
//   in_ready   high only in IDLE
//   op         funct3 (MUL..REMU)
//   word       RV64 W-variant select
//   opnum1     rs1 operand
//   opnum2     rs2 operand
//   out_valid  result valid (DONE state)
//   out_ready  downstream accepts the result
//   result     computed result, 0 whenever out_valid is low
//   busy       high whenever the state is not IDLE
module mdu_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] opnum1,
  input  logic [XLEN-1:0] opnum2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;
  logic [XLEN-1:0]   r_result;
  logic [XLEN-1:0]   r_opd;      // multiplicand magnitude, or divisor magnitude
  logic [2*XLEN-1:0] r_prod;     // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [CW-1:0]     r_cnt;
  logic              r_is_div;
  logic              r_hi;       // return the high half of the product
  logic              r_rem_sel;  // REM/REMU rather than DIV/DIVU
  logic              r_word;
  logic              r_neg_q;    // negate product / quotient
  logic              r_neg_r;    // negate remainder

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // ---------------------------------------------------------------------
  // Accept-side operand preparation (from the live inputs)
  // ---------------------------------------------------------------------
  logic            w_accept;
  logic            w_zext;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_a_ext;
  logic [XLEN-1:0] w_b_ext;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN-1:0] w_min;
  logic [XLEN-1:0] w_spec_raw;
  logic [XLEN-1:0] w_spec;

  always_comb begin
    w_accept = in_valid && r_in_ready;
    // Only DIVUW/REMUW zero-extend; every other W op sign-extends.
    w_zext   = word && op[2] && op[0];
    w_a_ext  = opnum1;
    w_b_ext  = opnum2;
    if (word) begin
      w_a_ext = w_zext ? {{(XLEN-32){1'b0}}, opnum1[31:0]} : sext32(opnum1[31:0]);
      w_b_ext = w_zext ? {{(XLEN-32){1'b0}}, opnum2[31:0]} : sext32(opnum2[31:0]);
    end

    if (op[2]) begin
      w_a_signed = !op[0];
      w_b_signed = !op[0];
    end else if (word) begin
      // Every W multiply behaves as MULW.
      w_a_signed = 1'b1;
      w_b_signed = 1'b1;
    end else begin
      // MUL's low half does not depend on signedness; treat it as signed.
      w_a_signed = (op[1:0] != 2'b11);
      w_b_signed = !op[1];
    end

    w_a_neg = w_a_signed && w_a_ext[XLEN-1];
    w_b_neg = w_b_signed && w_b_ext[XLEN-1];
    w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;

    // Most negative value of the active domain, as seen after extension.
    w_min  = word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    w_div0 = op[2] && (w_b_ext == '0);
    w_ovf  = op[2] && !op[0] && (w_a_ext == w_min) && (&w_b_ext);

    if (w_div0) w_spec_raw = op[1] ? w_a_ext : {XLEN{1'b1}};
    else        w_spec_raw = op[1] ? {XLEN{1'b0}} : w_a_ext;
    w_spec = word ? sext32(w_spec_raw[31:0]) : w_spec_raw;
  end

  // ---------------------------------------------------------------------
  // One iteration step plus final sign/format of the result
  // ---------------------------------------------------------------------
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_prod_next;
  logic [2*XLEN-1:0] w_prod_neg;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;
  logic [XLEN-1:0]   w_pick;
  logic [XLEN-1:0]   w_final;

  always_comb begin
    w_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, r_opd};
    // Shifted partial remainder {rem, next dividend bit} minus divisor.
    w_diff = r_prod[2*XLEN-1:XLEN-1] - {1'b0, r_opd};
    if (r_is_div) begin
      // Restoring: keep the shifted value when the trial went negative.
      w_prod_next = w_diff[XLEN] ? {r_prod[2*XLEN-2:0], 1'b0}
                                 : {w_diff[XLEN-1:0], r_prod[XLEN-2:0], 1'b1};
    end else begin
      w_prod_next = r_prod[0] ? {w_sum, r_prod[XLEN-1:1]}
                              : {1'b0, r_prod[2*XLEN-1:1]};
    end

    w_prod_neg = r_neg_q ? -w_prod_next : w_prod_next;
    w_q = r_neg_q ? -w_prod_next[XLEN-1:0]      : w_prod_next[XLEN-1:0];
    w_r = r_neg_r ? -w_prod_next[2*XLEN-1:XLEN] : w_prod_next[2*XLEN-1:XLEN];

    if (r_is_div) w_pick = r_rem_sel ? w_r : w_q;
    else          w_pick = r_hi ? w_prod_neg[2*XLEN-1:XLEN] : w_prod_neg[XLEN-1:0];
    w_final = r_word ? sext32(w_pick[31:0]) : w_pick;
  end

  // ---------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_opd       <= '0;
      r_prod      <= '0;
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_hi        <= 1'b0;
      r_rem_sel   <= 1'b0;
      r_word      <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_div   <= op[2];
            r_hi       <= !word && (op[1:0] != 2'b00);
            r_rem_sel  <= op[1];
            r_word     <= word;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_div0 || w_ovf) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_spec;
            end else begin
              r_state <= S_CALC;
              r_opd   <= op[2] ? w_b_mag : w_a_mag;
              r_prod  <= op[2] ? {{XLEN{1'b0}}, w_a_mag} : {{XLEN{1'b0}}, w_b_mag};
            end
          end
        end
        S_CALC: begin
          r_prod <= w_prod_next;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CW'(XLEN-1)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_final;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_result    <= '0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter (XLEN=64).
// Directed vector table, random operations against an arithmetic reference
// model, and hand-written backpressure and mid-operation reset sequences.
module tb_mdu_iter;
  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic            word;
  logic [XLEN-1:0] opnum1;
  logic [XLEN-1:0] opnum2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_iter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .opnum1(opnum1), .opnum2(opnum2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the RISC-V definitions.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [31:0]  r32;
    logic [63:0]  res;
    longint       sa;
    longint       sb;
    int           sa32;
    int           sb32;
    logic         ovf32;
    logic         ovf64;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0];
    ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    p = '0; r32 = '0; res = '0;
    if (w) begin
      case (o)
        3'd4: if (b[31:0] == 0) r32 = '1; else if (ovf32) r32 = a[31:0]; else r32 = sa32 / sb32;
        3'd5: r32 = (b[31:0] == 0) ? '1 : a[31:0] / b[31:0];
        3'd6: if (b[31:0] == 0) r32 = a[31:0]; else if (ovf32) r32 = '0; else r32 = sa32 % sb32;
        3'd7: r32 = (b[31:0] == 0) ? a[31:0] : a[31:0] % b[31:0];
        default: r32 = a[31:0] * b[31:0];
      endcase
      res = {{32{r32[31]}}, r32};
    end else begin
      case (o)
        3'd0: res = a * b;
        3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; res = p[127:64]; end
        3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       res = p[127:64]; end
        3'd3: begin p = {64'd0, a} * {64'd0, b};             res = p[127:64]; end
        3'd4: if (b == 0) res = '1; else if (ovf64) res = a; else res = sa / sb;
        3'd5: res = (b == 0) ? '1 : a / b;
        3'd6: if (b == 0) res = a; else if (ovf64) res = '0; else res = sa % sb;
        default: res = (b == 0) ? a : a % b;
      endcase
    end
    return res;
  endfunction

  // Expected cycle (1 = the cycle right after the accepting edge) of out_valid.
  function automatic int ref_lat(input logic [2:0] o, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    if (!o[2]) return XLEN + 1;
    if (w) begin
      if (b[31:0] == 0) return 1;
      if (!o[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
    end else begin
      if (b == 0) return 1;
      if (!o[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
    end
    return XLEN + 1;
  endfunction

  function automatic logic [63:0] pick_operand();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issue one op with out_ready=1, scramble inputs while busy, check result/latency.
  task automatic run_op(input string name, input logic [2:0] o, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat);
    int          cyc;
    logic        done;
    logic [63:0] got;
    @(negedge clk);
    check({name, " in_ready before"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = o; word = w; opnum1 = a; opnum2 = b; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Later input changes must have no effect.
    op = 3'($urandom); word = 1'($urandom);
    opnum1 = {$urandom, $urandom}; opnum2 = {$urandom, $urandom};
    cyc = 1; done = 1'b0; got = '0;
    check({name, " busy"}, 64'(busy), 64'd1);
    while (!done && cyc <= XLEN + 20) begin
      if (out_valid) begin
        got = result;
        done = 1'b1;
        in_valid = 1'b0;
      end else begin
        if (cyc == 1) check({name, " result zero while invalid"}, result, 64'd0);
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      in_valid = 1'b0;
      $display("FAIL %s timeout: out_valid never seen, required at cycle %0d", name, exp_lat);
    end else begin
      check({name, " result"}, got, exp);
      check({name, " latency"}, 64'(cyc), 64'(exp_lat));
    end
    $display("op=%0d word=%0d a=%h b=%h result=%h cycle=%0d", o, w, a, b, got, cyc);
    @(posedge clk);
    @(negedge clk);
    check({name, " idle after handshake {in_ready,out_valid}"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    logic [63:0] held;
    int          waited;

    rst = 1'b1; in_valid = 1'b0; op = '0; word = 1'b0;
    opnum1 = '0; opnum2 = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset result", result, 64'd0);

    vecs[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vecs[1]  = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[2]  = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[3]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[4]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[5]  = '{3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[6]  = '{3'd5, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[7]  = '{3'd6, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    vecs[8]  = '{3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 65};
    vecs[9]  = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[10] = '{3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1};
    vecs[11] = '{3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[12] = '{3'd7, 1'b1, 64'hFFFF_FFFF, 64'h10, 64'h0000_0000_0000_000F, 65};
    vecs[13] = '{3'd2, 1'b1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65};
    vecs[14] = '{3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1};

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].lat);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  ro;
      logic        rw;
      logic [63:0] ra;
      logic [63:0] rb;
      ro = 3'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      ra = pick_operand();
      rb = pick_operand();
      run_op($sformatf("rand%0d", i), ro, rw, ra, rb, ref_model(ro, rw, ra, rb), ref_lat(ro, rw, ra, rb));
    end

    // Backpressure: hold out_ready low in DONE for 5 cycles.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd0; word = 1'b0; opnum1 = 64'd6; opnum2 = 64'd7; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < XLEN + 20) begin
      @(negedge clk);
      waited++;
    end
    check("bp out_valid seen", 64'(out_valid), 64'd1);
    held = result;
    check("bp result", held, 64'd42);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d result", k), result, 64'd42);
      check($sformatf("bp hold%0d in_ready", k), 64'(in_ready), 64'd0);
      check($sformatf("bp hold%0d out_valid", k), 64'(out_valid), 64'd1);
    end
    $display("backpressure op=0 a=6 b=7 result=%h", held);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp after handshake in_ready", 64'(in_ready), 64'd1);
    check("bp after handshake out_valid", 64'(out_valid), 64'd0);
    check("bp after handshake result", result, 64'd0);

    // Reset in the middle of CALC, with in_valid presented on the same edge.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd4; word = 1'b0; opnum1 = 64'h0123_4567_89AB_CDEF; opnum2 = 64'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    check("abort still busy", 64'(busy), 64'd1);
    rst = 1'b1; in_valid = 1'b1; op = 3'd0; opnum1 = 64'd9; opnum2 = 64'd9;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort result", result, 64'd0);
    $display("reset abort during CALC cycle 20");
    run_op("post-reset MUL 3*4", 3'd0, 1'b0, 64'd3, 64'd4, 64'd12, XLEN + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
